// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: generates stall, freeze and flush
// controls for load-use hazards, slow data-memory accesses and taken branches.
module hazard_stall_unit #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 64,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             IF_ID_Use_RS1,
  input  logic             IF_ID_Use_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MemRead,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             DMEM_Ready,
  input  logic             EX_Branch_Taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             Mem_Timeout_Err,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [1:0]       Hazard_State
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        lu_cnt_reg, lu_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

  logic lu_hit;
  logic mem_busy;
  logic resume_lu;

  assign lu_hit = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                  ((IF_ID_Use_RS1 && (IF_ID_RS1 == ID_EX_RD)) ||
                   (IF_ID_Use_RS2 && (IF_ID_RS2 == ID_EX_RD)));
  assign mem_busy = (EX_MEM_MemRead || EX_MEM_MemWrite) && !DMEM_Ready;
  // Bubbles still owed from a load-use stall that a memory freeze interrupted.
  assign resume_lu = (state_reg == LU_STALL) ||
                     ((state_reg == MEM_WAIT) && (lu_cnt_reg != 2'd0));

  always_comb begin
    state_next    = state_reg;
    lu_cnt_next   = lu_cnt_reg;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    if (rst) begin
      state_next  = RUN;
      lu_cnt_next = 2'd0;
    end else if (mem_busy) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
      state_next    = MEM_WAIT;
    end else if (EX_Branch_Taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      state_next  = RUN;
      lu_cnt_next = 2'd0;
    end else if (resume_lu) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (state_reg == MEM_WAIT) begin
        state_next = LU_STALL;
      end else begin
        lu_cnt_next = lu_cnt_reg - 2'd1;
        state_next  = (lu_cnt_reg == 2'd1) ? RUN : LU_STALL;
      end
    end else if (lu_hit) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        state_next  = LU_STALL;
        lu_cnt_next = LU_RELOAD;
      end else begin
        state_next = RUN;
      end
    end else begin
      state_next = RUN;
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (mem_busy) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);
    end
    err_next = err_reg || (mem_busy && (wait_cnt_reg == WAIT_MAX));
    stall_cnt_next = stall_cnt_reg;
    if (!PC_Write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      lu_cnt_reg    <= 2'd0;
      wait_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      lu_cnt_reg    <= lu_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      err_reg       <= err_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Status reads as its reset value for the whole time rst is held.
  assign Hazard_State    = rst ? 2'b00 : state_reg;
  assign Stall_Count     = rst ? '0 : stall_cnt_reg;
  assign Mem_Timeout_Err = rst ? 1'b0 : err_reg;

endmodule
